// File: rtl/countdown_sequencer.sv
// rtl/countdown_sequencer.sv - sequenced countdown controller with prescaler, pause and abort
//
// Purpose:
//   Loads a start value into a down-counter and decrements it once every
//   PRESCALE clock cycles. Supports pause (hold), abort, and a one-cycle
//   Moore done pulse at terminal count.
//
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN
//   Defined   : DONE restarts the countdown from the last loaded value
//               (unless that value was zero).
//   Undefined : DONE always returns to IDLE; no reload register exists.
//
// Parameters:
//   WIDTH     counter width in bits
//   PRESCALE  clock cycles per decrement tick (1..65535)
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   start     begin a countdown (IDLE only)
//   load_val  start value, sampled with an accepted start
//   hold      level; pauses RUN while high
//   abort     return to IDLE from any state
//   count     current counter value
//   busy      high in RUN or PAUSE
//   paused    high in PAUSE
//   done      high in DONE
//   state     IDLE=0, RUN=1, PAUSE=2, DONE=3

module countdown_sequencer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             hold,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             paused,
   output logic             done,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [15:0]      pre_q,   pre_d;
   logic             tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   // Only meaningful while counting; IDLE and DONE never consult it.
   assign tick = (pre_q == PRE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         pre_q    <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         pre_q    <= pre_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      pre_d    = pre_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (abort) begin
               // Abort beats a simultaneous start; stay idle.
               count_d = CNT_ZERO;
               pre_d   = '0;
            end else if (start) begin
               pre_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               // A zero start also clears reload so DONE does not restart
               // a stale countdown from an earlier run.
               reload_d = load_val;
`endif
               if (load_val != CNT_ZERO) begin
                  count_d = load_val;
                  state_d = S_RUN;
               end else begin
                  count_d = CNT_ZERO;
                  state_d = S_DONE;
               end
            end
         end

         // RUN and PAUSE share one body: any cycle with hold high is frozen,
         // and a PAUSE cycle with hold low behaves exactly like a RUN cycle
         // (the prescaler advances and may tick). That makes every held
         // cycle cost exactly one cycle of schedule.
         S_RUN, S_PAUSE: begin
            if (abort) begin
               state_d = S_IDLE;
               count_d = CNT_ZERO;
               pre_d   = '0;
            end else if (hold) begin
               state_d = S_PAUSE;
            end else begin
               state_d = S_RUN;
               if (tick) begin
                  pre_d = '0;
                  if (count_q > CNT_ONE) begin
                     count_d = count_q - CNT_ONE;
                  end else begin
                     count_d = CNT_ZERO;
                     state_d = S_DONE;
                  end
               end else begin
                  pre_d = pre_q + 16'd1;
               end
            end
         end

         S_DONE: begin
            count_d = CNT_ZERO;
            pre_d   = '0;
            state_d = S_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (!abort && (reload_q != CNT_ZERO)) begin
               count_d = reload_q;
               state_d = S_RUN;
            end
`endif
         end

         default: begin
            state_d = S_IDLE;
            count_d = CNT_ZERO;
            pre_d   = '0;
         end
      endcase
   end

   // Moore outputs, decoded from registered state only.
   assign count  = count_q;
   assign state  = state_q;
   assign busy   = (state_q == S_RUN) || (state_q == S_PAUSE);
   assign paused = (state_q == S_PAUSE);
   assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_countdown_sequencer.sv
// tb/tb_countdown_sequencer.sv - table-driven bench for countdown_sequencer

module tb_countdown_sequencer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // DUT with PRESCALE = 1
   logic       rst, start, hold, abort;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       busy, paused, done;
   logic [1:0] state;

   // DUT with PRESCALE = 3
   logic       rst3, start3, hold3, abort3;
   logic [3:0] load_val3;
   logic [3:0] count3;
   logic       busy3, paused3, done3;
   logic [1:0] state3;

   countdown_sequencer #(.WIDTH(4), .PRESCALE(1)) dut (
      .clk(clk), .rst(rst), .start(start), .load_val(load_val), .hold(hold),
      .abort(abort), .count(count), .busy(busy), .paused(paused), .done(done),
      .state(state)
   );

   countdown_sequencer #(.WIDTH(4), .PRESCALE(3)) dut3 (
      .clk(clk), .rst(rst3), .start(start3), .load_val(load_val3), .hold(hold3),
      .abort(abort3), .count(count3), .busy(busy3), .paused(paused3), .done(done3),
      .state(state3)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst, start, hold, abort;
      logic [3:0] lv;
      logic [3:0] cnt;
      logic [1:0] st;
   } vec_t;

   function automatic vec_t v(input logic r, input logic s, input logic [3:0] lv,
                              input logic h, input logic a,
                              input logic [3:0] cnt, input logic [1:0] st);
      vec_t x;
      x.rst = r; x.start = s; x.lv = lv; x.hold = h; x.abort = a;
      x.cnt = cnt; x.st = st;
      return x;
   endfunction

   localparam logic [1:0] I = 2'd0, R = 2'd1, P = 2'd2, D = 2'd3;

   // One clock: inputs already driven, take the edge, sample 1 time unit later.
   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state1(input string tag, input logic [3:0] ecnt, input logic [1:0] est);
      check({tag, " count"},  count,  ecnt);
      check({tag, " state"},  state,  est);
      check({tag, " busy"},   busy,   (est == R) || (est == P));
      check({tag, " paused"}, paused, est == P);
      check({tag, " done"},   done,   est == D);
   endtask

   vec_t vt[$];

   initial begin
      rst = 1'b1; start = 0; hold = 0; abort = 0; load_val = '0;
      rst3 = 1'b1; start3 = 0; hold3 = 0; abort3 = 0; load_val3 = '0;
      tick_clk();
      check_state1("reset", 4'd0, I);
      check("reset3 state", state3, I);
      check("reset3 count", count3, 4'd0);
      rst = 0; rst3 = 0;

`ifndef COUNTDOWN_AUTO_RELOAD_EN
      //           rst st  lv   hd ab  cnt  state
      vt.push_back(v(1, 0, 4'd0, 0, 0, 4'd0,  I));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  I));
      // basic countdown, load 4
      vt.push_back(v(0, 1, 4'd4, 0, 0, 4'd4,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd3,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd2,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd1,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  D));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  I));
      // zero load goes straight to DONE
      vt.push_back(v(0, 1, 4'd0, 0, 0, 4'd0,  D));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  I));
      // second start ignored in RUN, then abort at count 3
      vt.push_back(v(0, 1, 4'd5, 0, 0, 4'd5,  R));
      vt.push_back(v(0, 1, 4'd9, 0, 0, 4'd4,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd3,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 1, 4'd0,  I));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  I));
      // start with abort in IDLE
      vt.push_back(v(0, 1, 4'd7, 0, 1, 4'd0,  I));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  I));
      // hold with the terminal tick, then release
      vt.push_back(v(0, 1, 4'd2, 0, 0, 4'd2,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd1,  R));
      vt.push_back(v(0, 0, 4'd0, 1, 0, 4'd1,  P));
      vt.push_back(v(0, 0, 4'd0, 1, 0, 4'd1,  P));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  D));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  I));
      // hold and start ignored in DONE
      vt.push_back(v(0, 1, 4'd1, 0, 0, 4'd1,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  D));
      vt.push_back(v(0, 1, 4'd6, 1, 0, 4'd0,  I));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  I));
      // abort during DONE: DONE cycle already shown, then IDLE
      vt.push_back(v(0, 1, 4'd1, 0, 0, 4'd1,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd0,  D));
      vt.push_back(v(0, 0, 4'd0, 0, 1, 4'd0,  I));
      // reset mid-RUN at count 5
      vt.push_back(v(0, 1, 4'd8, 0, 0, 4'd8,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd7,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd6,  R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd5,  R));
      vt.push_back(v(1, 0, 4'd0, 0, 0, 4'd0,  I));
      // maximum load
      vt.push_back(v(0, 1, 4'd15, 0, 0, 4'd15, R));
      vt.push_back(v(0, 0, 4'd0, 0, 0, 4'd14, R));
      vt.push_back(v(0, 0, 4'd0, 0, 1, 4'd0,  I));
      // abort while paused
      vt.push_back(v(0, 1, 4'd3, 0, 0, 4'd3,  R));
      vt.push_back(v(0, 0, 4'd0, 1, 0, 4'd3,  P));
      vt.push_back(v(0, 0, 4'd0, 1, 1, 4'd0,  I));
      // reset beats start
      vt.push_back(v(1, 1, 4'd3, 0, 0, 4'd0,  I));

      foreach (vt[i]) begin
         rst = vt[i].rst; start = vt[i].start; load_val = vt[i].lv;
         hold = vt[i].hold; abort = vt[i].abort;
         tick_clk();
         check_state1($sformatf("vec%0d", i), vt[i].cnt, vt[i].st);
      end
      rst = 0; start = 0; hold = 0; abort = 0; load_val = '0;
`else
      begin
         // auto-reload: load 3, done at N+4, N+8; abort in cycle N+10
         logic [3:0] ecnt [1:12];
         logic [1:0] est  [1:12];
         ecnt = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd0, 4'd0};
         est  = '{R, R, R, D, R, R, R, D, R, R, I, I};
         start = 1; load_val = 4'd3;
         tick_clk();
         start = 0; load_val = '0;
         check_state1("reload c1", ecnt[1], est[1]);
         for (int k = 1; k < 12; k++) begin
            abort = (k == 10);
            tick_clk();
            check_state1($sformatf("reload c%0d", k + 1), ecnt[k + 1], est[k + 1]);
         end
         abort = 0;
      end
`endif

      // PRESCALE = 3, load 2, hold high during cycles N+2 and N+3
      begin
         logic [3:0] pcnt [1:9];
         logic [1:0] pst  [1:9];
         int         npaused;
         pcnt = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0};
         pst  = '{R, R, P, P, R, R, R, R, D};
         npaused = 0;
         start3 = 1; load_val3 = 4'd2;
         tick_clk();
         start3 = 0; load_val3 = '0;
         for (int c = 1; c <= 9; c++) begin
            check($sformatf("pre3 c%0d count", c), count3, pcnt[c]);
            check($sformatf("pre3 c%0d state", c), state3, pst[c]);
            check($sformatf("pre3 c%0d done", c), done3, c == 9);
            if (paused3) npaused++;
            if (c < 9) begin
               hold3 = (c == 2) || (c == 3);
               tick_clk();
            end
         end
         hold3 = 0;
         check("pre3 paused cycles", npaused, 2);
         tick_clk();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         check("pre3 after done state", state3, R);
         check("pre3 after done count", count3, 4'd2);
         abort3 = 1;
         tick_clk();
         abort3 = 0;
         check("pre3 abort state", state3, I);
`else
         check("pre3 after done state", state3, I);
         check("pre3 after done count", count3, 4'd0);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
